// File: rtl/vx_fetch_ibuf.sv
// vx_fetch_ibuf: per-warp instruction buffer between fetch response and decode.
// One circular queue per warp; decode is fed by round-robin arbitration across
// non-empty warps, with a lock that holds the presented entry until accepted.
// Optional macro IBUF_PERF_EN: enables the stall/instruction performance counters
// (otherwise both perf ports are tied to zero and no counter flops exist).
module vx_fetch_ibuf #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned IBUF_SIZE   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [$clog2(NUM_WARPS)-1:0] in_wid,
  input  logic [NUM_THREADS-1:0]       in_tmask,
  input  logic [31:0]                  in_PC,
  input  logic [31:0]                  in_instr,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [$clog2(NUM_WARPS)-1:0] out_wid,
  output logic [NUM_THREADS-1:0]       out_tmask,
  output logic [31:0]                  out_PC,
  output logic [31:0]                  out_instr,
  input  logic                         out_ready,
  input  logic                         flush_valid,
  input  logic [$clog2(NUM_WARPS)-1:0] flush_wid,
  output logic [31:0]                  perf_stall_cycles,
  output logic [31:0]                  perf_instrs,
  output logic                         busy
);

  localparam int unsigned WW = $clog2(NUM_WARPS);
  localparam int unsigned PW = $clog2(IBUF_SIZE);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
    logic [31:0]            instr;
  } entry_t;

  entry_t               mem    [NUM_WARPS][IBUF_SIZE];
  logic [PW-1:0]        rd_ptr [NUM_WARPS];
  logic [PW-1:0]        wr_ptr [NUM_WARPS];
  logic [CW-1:0]        count  [NUM_WARPS];

  logic [NUM_WARPS-1:0] nonempty;
  logic [NUM_WARPS-1:0] push_vec;
  logic [NUM_WARPS-1:0] pop_vec;
  logic [NUM_WARPS-1:0] flush_vec;
  logic [WW-1:0]        rr_ptr;
  logic [WW-1:0]        rr_sel;
  logic [WW-1:0]        sel;
  logic [WW-1:0]        lock_wid;
  logic                 lock_valid;
  logic                 in_fire;
  logic                 out_fire;
  entry_t               head;

  // Per-warp occupancy and push/pop/flush decode
  always_comb begin
    nonempty  = '0;
    push_vec  = '0;
    pop_vec   = '0;
    flush_vec = '0;
    for (int w = 0; w < int'(NUM_WARPS); w++) begin
      nonempty[w]  = (count[w] != '0);
      push_vec[w]  = in_fire && (in_wid == WW'(w));
      pop_vec[w]   = out_fire && (sel == WW'(w));
      flush_vec[w] = flush_valid && (flush_wid == WW'(w));
    end
  end

  assign busy     = |nonempty;
  assign in_ready = (count[in_wid] != CW'(IBUF_SIZE));
  assign in_fire  = in_valid & in_ready;

  // Round-robin search from rr_ptr; walking downward leaves the closest hit
  always_comb begin
    rr_sel = rr_ptr;
    for (int i = int'(NUM_WARPS) - 1; i >= 0; i--) begin
      if (nonempty[rr_ptr + WW'(i)]) rr_sel = rr_ptr + WW'(i);
    end
  end

  assign sel       = lock_valid ? lock_wid : rr_sel;
  assign out_valid = lock_valid | busy;
  assign out_fire  = out_valid & out_ready;
  assign head      = mem[sel][rd_ptr[sel]];
  assign out_wid   = sel;
  assign out_tmask = head.tmask;
  assign out_PC    = head.pc;
  assign out_instr = head.instr;

  // Entry storage; a write into a warp being flushed is simply never read
  always_ff @(posedge clk) begin
    if (in_fire) mem[in_wid][wr_ptr[in_wid]] <= entry_t'{tmask: in_tmask, pc: in_PC, instr: in_instr};
  end

  // Queue pointers and counts; flush overrides a coincident push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < int'(NUM_WARPS); w++) begin
        rd_ptr[w] <= '0;
        wr_ptr[w] <= '0;
        count[w]  <= '0;
      end
    end else begin
      for (int w = 0; w < int'(NUM_WARPS); w++) begin
        if (flush_vec[w]) begin
          rd_ptr[w] <= '0;
          wr_ptr[w] <= '0;
          count[w]  <= '0;
        end else begin
          if (push_vec[w]) wr_ptr[w] <= wr_ptr[w] + PW'(1);
          if (pop_vec[w])  rd_ptr[w] <= rd_ptr[w] + PW'(1);
          case ({push_vec[w], pop_vec[w]})
            2'b10:   count[w] <= count[w] + CW'(1);
            2'b01:   count[w] <= count[w] - CW'(1);
            default: count[w] <= count[w];
          endcase
        end
      end
    end
  end

  // Arbitration pointer and output lock; a flush of the held warp drops the lock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_wid   <= '0;
    end else begin
      if (out_fire) rr_ptr <= sel + WW'(1);
      lock_valid <= out_valid && !out_ready && !(flush_valid && (flush_wid == sel));
      if (out_valid && !out_ready) lock_wid <= sel;
    end
  end

`ifdef IBUF_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] instr_cnt;

  // Wrap-around performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (in_valid && !in_ready) stall_cnt <= stall_cnt + 32'd1;
      if (out_fire)              instr_cnt <= instr_cnt + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt;
  assign perf_instrs       = instr_cnt;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_instrs       = 32'd0;
`endif

endmodule

// File: tb/tb_vx_fetch_ibuf.sv
// Directed self-checking bench for vx_fetch_ibuf (default parameters).
module tb_vx_fetch_ibuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_wid;
  logic [3:0]  in_tmask;
  logic [31:0] in_PC;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_wid;
  logic [3:0]  out_tmask;
  logic [31:0] out_PC;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush_valid;
  logic [1:0]  flush_wid;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_instrs;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  vx_fetch_ibuf dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_wid(in_wid), .in_tmask(in_tmask), .in_PC(in_PC), .in_instr(in_instr),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_wid(out_wid), .out_tmask(out_tmask), .out_PC(out_PC), .out_instr(out_instr),
    .out_ready(out_ready),
    .flush_valid(flush_valid), .flush_wid(flush_wid),
    .perf_stall_cycles(perf_stall_cycles), .perf_instrs(perf_instrs), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] tm_of(input logic [31:0] pc);
    return pc[5:2] ^ 4'h5;
  endfunction

  // Expected perf counter value: real count when counters are built, else zero
  function automatic logic [31:0] perf_exp(input int n);
`ifdef IBUF_PERF_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n - n);
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_wid = '0; in_tmask = '0; in_PC = '0; in_instr = '0;
    out_ready = 1'b0; flush_valid = 1'b0; flush_wid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle push; returns at the following falling edge
  task automatic push(input logic [1:0] w, input logic [31:0] pc);
    in_valid = 1'b1; in_wid = w; in_PC = pc; in_tmask = tm_of(pc); in_instr = ~pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_wid = '0; out_ready = 1'b0; flush_valid = 1'b0; flush_wid = '0;
    in_tmask = '0; in_PC = '0; in_instr = '0;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if (perf_instrs !== 32'd0 || perf_stall_cycles !== 32'd0) begin n_fail++;
      $display("FAIL reset_perf got %0d/%0d want 0/0", perf_stall_cycles, perf_instrs); end
    reset = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_wid = 2'd2; in_PC = 32'h8000_0000; in_tmask = tm_of(32'h8000_0000); in_instr = 32'h7fff_ffff;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass got %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_wid !== 2'd2 || out_PC !== 32'h8000_0000) begin n_fail++;
      $display("FAIL first_push got v=%b w=%0d pc=%h want v=1 w=2 pc=80000000", out_valid, out_wid, out_PC); end
    n_tests++; if (out_instr !== 32'h7fff_ffff || out_tmask !== tm_of(32'h8000_0000) || busy !== 1'b1) begin n_fail++;
      $display("FAIL first_fields got instr=%h tm=%h busy=%b", out_instr, out_tmask, busy); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || perf_instrs !== perf_exp(1)) begin n_fail++;
      $display("FAIL first_pop got v=%b instrs=%0d want v=0 instrs=%0d", out_valid, perf_instrs, perf_exp(1)); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 4; k++) push(2'd1, 32'h4000 + 32'(k * 4));
    in_valid = 1'b1; in_wid = 2'd1; in_PC = 32'h4010; in_tmask = tm_of(32'h4010); in_instr = ~32'h4010;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready_w1 got %b want 0", in_ready); end
    in_wid = 2'd0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready_w0 got %b want 1", in_ready); end
    in_wid = 2'd1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (perf_stall_cycles !== perf_exp(3)) begin n_fail++;
      $display("FAIL stall_count got %0d want %0d", perf_stall_cycles, perf_exp(3)); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (out_valid !== 1'b1 || out_wid !== 2'd1 || out_PC !== 32'h4000 + 32'(k * 4)) begin n_fail++;
        $display("FAIL full_drain%0d got v=%b w=%0d pc=%h want w=1 pc=%h", k, out_valid, out_wid, out_PC, 32'h4000 + 32'(k * 4)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL full_empty got v=%b busy=%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  ew;
    logic [31:0] epc;
    do_reset();
    push(2'd0, 32'h1000); push(2'd0, 32'h1004);
    push(2'd1, 32'h1100); push(2'd1, 32'h1104);
    push(2'd3, 32'h1300); push(2'd3, 32'h1304);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ew  = (k % 3 == 2) ? 2'd3 : 2'(k % 3);
      epc = 32'h1000 + 32'(ew) * 32'h100 + 32'((k / 3) * 4);
      n_tests++; if (out_valid !== 1'b1 || out_wid !== ew || out_PC !== epc) begin n_fail++;
        $display("FAIL rr_order%0d got w=%0d pc=%h want w=%0d pc=%h", k, out_wid, out_PC, ew, epc); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || perf_instrs !== perf_exp(6)) begin n_fail++;
      $display("FAIL rr_done got v=%b instrs=%0d want v=0 instrs=%0d", out_valid, perf_instrs, perf_exp(6)); end
  endtask

  task automatic test_lock();
    do_reset();
    push(2'd2, 32'h2000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    // rr_ptr now points at warp 3
    push(2'd0, 32'h3000);
    push(2'd3, 32'h3300);
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (out_wid !== 2'd0 || out_PC !== 32'h3000 || out_instr !== ~32'h3000 || out_tmask !== tm_of(32'h3000)) begin n_fail++;
        $display("FAIL lock_hold%0d got w=%0d pc=%h want w=0 pc=00003000", k, out_wid, out_PC); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1 || out_wid !== 2'd3 || out_PC !== 32'h3300) begin n_fail++;
      $display("FAIL lock_next got w=%0d pc=%h want w=3 pc=00003300", out_wid, out_PC); end
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lock_empty got %b want 0", out_valid); end
  endtask

  task automatic test_full_push_pop_flush();
    do_reset();
    for (int k = 0; k < 4; k++) push(2'd2, 32'h5000 + 32'(k * 4));
    in_valid = 1'b1; in_wid = 2'd2; in_PC = 32'h5010; in_tmask = tm_of(32'h5010); in_instr = ~32'h5010;
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0 || out_PC !== 32'h5000) begin n_fail++;
      $display("FAIL full_pop_blocked got rdy=%b pc=%h want rdy=0 pc=00005000", in_ready, out_PC); end
    @(negedge clk);
    in_PC = 32'h5014; in_tmask = tm_of(32'h5014); in_instr = ~32'h5014;
    #1;
    n_tests++; if (in_ready !== 1'b1 || out_PC !== 32'h5004) begin n_fail++;
      $display("FAIL pushpop_ready got rdy=%b pc=%h want rdy=1 pc=00005004", in_ready, out_PC); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    push(2'd2, 32'h5018);
    n_tests++; if (in_ready !== 1'b0 || out_PC !== 32'h5008) begin n_fail++;
      $display("FAIL pushpop_count got rdy=%b pc=%h want rdy=0 pc=00005008", in_ready, out_PC); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_wid = 2'd2; in_PC = 32'h5020; in_tmask = tm_of(32'h5020); in_instr = ~32'h5020;
    flush_valid = 1'b1; flush_wid = 2'd2;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_push_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; flush_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush_push_empty got v=%b busy=%b rdy=%b want 0/0/1", out_valid, busy, in_ready); end
  endtask

  task automatic test_flush_pop();
    do_reset();
    push(2'd0, 32'h6000); push(2'd0, 32'h6004); push(2'd1, 32'h6100);
    out_ready = 1'b1; flush_valid = 1'b1; flush_wid = 2'd1;
    #1;
    n_tests++; if (out_wid !== 2'd0 || out_PC !== 32'h6000) begin n_fail++;
      $display("FAIL flush_other_pop got w=%0d pc=%h want w=0 pc=00006000", out_wid, out_PC); end
    @(negedge clk);
    flush_wid = 2'd0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_wid !== 2'd0 || out_PC !== 32'h6004) begin n_fail++;
      $display("FAIL flush_same_pop got v=%b w=%0d pc=%h want v=1 w=0 pc=00006004", out_valid, out_wid, out_PC); end
    @(negedge clk);
    flush_valid = 1'b0; out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || perf_instrs !== perf_exp(2)) begin n_fail++;
      $display("FAIL flush_pop_done got v=%b busy=%b instrs=%0d want 0/0/%0d", out_valid, busy, perf_instrs, perf_exp(2)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(2'd0, 32'h7000); push(2'd1, 32'h7100); push(2'd2, 32'h7200);
    n_tests++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_fail++;
      $display("FAIL mid_loaded got busy=%b v=%b want 1/1", busy, out_valid); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL mid_reset got v=%b busy=%b rdy=%b want 0/0/1", out_valid, busy, in_ready); end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1; in_wid = 2'd1; in_PC = 32'h7400; in_tmask = tm_of(32'h7400); in_instr = ~32'h7400;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_bypass got %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_wid !== 2'd1 || out_PC !== 32'h7400) begin n_fail++;
      $display("FAIL mid_repush got v=%b w=%0d pc=%h want v=1 w=1 pc=00007400", out_valid, out_wid, out_PC); end
  endtask

  initial begin
    test_reset();
    test_full();
    test_round_robin();
    test_lock();
    test_full_push_pop_flush();
    test_flush_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
